axis_frame_arbiter: RTL and testbench
=====================================

AXIS_FRAME_ARBITER -- requirements
Module: axis_frame_arbiter

Interface
REQ-001 Parameter: N_SRC, 2, number of requesting sources (legal 2..4).
REQ-002 Parameter: MAX_BEATS, 256, watchdog beat limit per frame (used only with the watchdog macro, legal 2..65535).
REQ-003 Port: clk  input  1  single clock; all logic on rising edge.
REQ-004 Port: rst  input  1  reset, synchronous, active-high.
REQ-005 Port: channel_up  input  1  link ready; grants are issued only while high.
REQ-006 Port: req  input  N_SRC  per-source frame request; source holds its bit high until it sees its gnt bit.
REQ-007 Port: gnt  output  N_SRC  one-hot or zero grant, registered.
REQ-008 Port: s_valid  input  N_SRC  per-source beat valid.
REQ-009 Port: s_last  input  N_SRC  per-source end of frame.
REQ-010 Port: s_data  input  64*N_SRC  per-source data; source k occupies bits [64k+63:64k].
REQ-011 Port: m_axis  axi_stream_if.master  valid/last/data[63:0]  shared output stream, registered.
REQ-012 Port: abort  output  1  one-cycle pulse when a granted frame is cut short.
REQ-013 Port: stray  output  1  one-cycle pulse when s_valid is high on a non-granted source.

Function
REQ-014 The FSM shall have two states: IDLE (gnt=0) and BUSY (exactly one gnt bit high).
REQ-015 In IDLE, when channel_up=1 and req!=0, the block shall select a winner round-robin, starting at pointer rr_ptr, and shall assert gnt[winner] and enter BUSY on the next edge.
REQ-016 In IDLE with channel_up=0, no grant shall be issued, regardless of req.
REQ-017 In BUSY, each cycle with s_valid[winner]=1 shall produce, one cycle later, m_axis.valid=1 with m_axis.data=s_data[winner] and m_axis.last=s_last[winner]; otherwise m_axis.valid=0, last=0, data holds its previous value.
REQ-018 Latency s_valid to m_axis.valid shall be exactly 1 cycle; there is no backpressure, so no beat is dropped or stalled while granted.
REQ-019 On a granted beat with s_last=1: gnt shall drop on the next edge; the FSM shall return to IDLE; rr_ptr shall become (winner+1) mod N_SRC.
REQ-020 After a frame ends, at least one IDLE cycle shall elapse before the next gnt rises (gnt-to-gnt gap >= 1 cycle).
REQ-021 Any grant is frame-granular: no source switch shall occur mid-frame.
REQ-022 If channel_up falls while in BUSY: gnt shall drop on the next edge; the FSM shall enter IDLE; abort shall pulse once; the beat sampled in that same cycle shall be forwarded with last forced to 1 if valid, otherwise no output beat is generated; rr_ptr shall advance as in REQ-019.
REQ-023 s_valid on a non-granted source (including any source in IDLE) shall be ignored for output and shall pulse stray the next cycle.
REQ-024 Simultaneous s_last on the granted source and channel_up falling shall be treated as normal frame end: no abort pulse.
REQ-025 A req bit dropped before its grant shall simply withdraw the request; no state shall change.

Reset
REQ-026 While rst=1 at a clock edge: state=IDLE, gnt=0, rr_ptr=0, m_axis.valid=0, m_axis.last=0, m_axis.data=0, abort=0, stray=0, beat counter=0.
REQ-027 Reset asserted mid-frame shall take effect on the next edge: gnt drops and no terminating last is emitted.

Configuration
REQ-028 With macro AXIS_ARB_WATCHDOG_EN defined: a 16-bit beat counter shall count granted beats. On beat number MAX_BEATS without s_last, that beat shall be forwarded with last forced to 1, the grant shall be released as in REQ-019, and abort shall pulse once.
REQ-029 Without AXIS_ARB_WATCHDOG_EN, no beat counter shall exist and frames shall be unbounded.

Verification
REQ-030 rst, then channel_up=1, req=2'b01, 3-beat frame on src0 (data 0x11,0x22,0x33 with last on 0x33) -> gnt=01 one cycle after req; m_axis shows the same 3 beats each 1 cycle late, last on 0x33; gnt drops the next cycle.
REQ-031 req=2'b11 held, each source sends 1-beat frames -> grant order src0, src1, src0, src1, with >=1 idle cycle between grants.
REQ-032 channel_up=0, req=2'b01 for 10 cycles -> gnt stays 0; raise channel_up -> gnt=01 on the next edge.
REQ-033 channel_up drops on the 2nd beat of a 5-beat frame -> that beat is output with last=1, abort pulses once, gnt=0, further src beats raise stray.
REQ-034 With AXIS_ARB_WATCHDOG_EN, MAX_BEATS=4, send a 6-beat frame -> beat 4 is output with last=1, abort pulses, beats 5-6 pulse stray.
REQ-035 rst asserted on the 3rd beat of a frame -> next cycle gnt=0, m_axis.valid=0, rr_ptr=0.

Source files
------------

// File: rtl/axis_frame_arbiter_if.sv
// Shared AXI-Stream style output bundle (valid/last/64-bit data) used by
// axis_frame_arbiter; no backpressure, so there is no ready signal.
interface axi_stream_if;
   logic        valid;
   logic        last;
   logic [63:0] data;

   modport master (output valid, output last, output data);
   modport slave  (input  valid, input  last, input  data);
endinterface

// File: rtl/axis_frame_arbiter.sv
// Frame-granular round-robin arbiter merging N_SRC streams onto one output.
// Optional per-frame beat watchdog is enabled by defining AXIS_ARB_WATCHDOG_EN.
module axis_frame_arbiter #(
   parameter int N_SRC     = 2,
   parameter int MAX_BEATS = 256
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 channel_up,
   input  logic [N_SRC-1:0]     req,
   output logic [N_SRC-1:0]     gnt,
   input  logic [N_SRC-1:0]     s_valid,
   input  logic [N_SRC-1:0]     s_last,
   input  logic [64*N_SRC-1:0]  s_data,
   axi_stream_if.master         m_axis,
   output logic                 abort,
   output logic                 stray
);

   localparam int PW = (N_SRC > 2) ? 2 : 1;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   // Elaboration-time legality check of the configuration
   generate
      if ((N_SRC < 2) || (N_SRC > 4) || (MAX_BEATS < 2) || (MAX_BEATS > 65535)) begin : g_bad_cfg
         $error("axis_frame_arbiter: illegal N_SRC or MAX_BEATS");
      end
   endgenerate

   state_t            r_state;
   logic [N_SRC-1:0]  r_gnt;
   logic [PW-1:0]     r_winner;
   logic [PW-1:0]     r_rr_ptr;
   logic              r_m_valid;
   logic              r_m_last;
   logic [63:0]       r_m_data;
   logic              r_abort;
   logic              r_stray;

   state_t            w_state_nxt;
   logic [N_SRC-1:0]  w_gnt_nxt;
   logic [PW-1:0]     w_winner_nxt;
   logic [PW-1:0]     w_rr_nxt;
   logic              w_m_valid_nxt;
   logic              w_m_last_nxt;
   logic [63:0]       w_m_data_nxt;
   logic              w_abort_nxt;
   logic              w_stray_nxt;

   logic              w_found;
   logic [PW-1:0]     w_pick;
   logic [N_SRC-1:0]  w_pick_onehot;
   logic [PW-1:0]     w_ptr_inc;
   logic [63:0]       w_sel_data;
   logic              w_beat;
   logic              w_src_last;
   logic              w_wd_hit;

   // Round-robin search: first requesting source at or after r_rr_ptr
   always_comb begin
      w_found = 1'b0;
      w_pick  = '0;
      for (int i = 0; i < N_SRC; i++) begin
         if (!w_found && req[(int'(r_rr_ptr) + i) % N_SRC]) begin
            w_found = 1'b1;
            w_pick  = PW'((int'(r_rr_ptr) + i) % N_SRC);
         end else begin
            w_found = w_found;
         end
      end
   end

   assign w_pick_onehot = {{(N_SRC-1){1'b0}}, 1'b1} << w_pick;
   assign w_ptr_inc     = (r_winner == PW'(N_SRC-1)) ? '0 : (r_winner + PW'(1));
   assign w_sel_data    = s_data[int'(r_winner)*64 +: 64];
   assign w_beat        = (r_state == BUSY) && s_valid[r_winner];
   assign w_src_last    = s_last[r_winner];

`ifdef AXIS_ARB_WATCHDOG_EN
   logic [15:0] r_beat_cnt;

   assign w_wd_hit = w_beat && !w_src_last && (r_beat_cnt == 16'(MAX_BEATS - 1));

   // Granted-beat counter; cleared whenever no frame is in progress
   always_ff @(posedge clk) begin
      if (rst) begin
         r_beat_cnt <= 16'd0;
      end else if (r_state != BUSY) begin
         r_beat_cnt <= 16'd0;
      end else if (w_beat) begin
         r_beat_cnt <= r_beat_cnt + 16'd1;
      end else begin
         r_beat_cnt <= r_beat_cnt;
      end
   end
`else
   assign w_wd_hit = 1'b0;
`endif

   // Next-state and registered-output decode
   always_comb begin
      w_state_nxt   = r_state;
      w_gnt_nxt     = r_gnt;
      w_winner_nxt  = r_winner;
      w_rr_nxt      = r_rr_ptr;
      w_m_valid_nxt = 1'b0;
      w_m_last_nxt  = 1'b0;
      w_m_data_nxt  = r_m_data;
      w_abort_nxt   = 1'b0;
      w_stray_nxt   = |(s_valid & ~r_gnt);

      case (r_state)
         IDLE: begin
            w_gnt_nxt = '0;
            if (channel_up && w_found) begin
               w_state_nxt  = BUSY;
               w_winner_nxt = w_pick;
               w_gnt_nxt    = w_pick_onehot;
            end else begin
               w_state_nxt  = IDLE;
            end
         end
         BUSY: begin
            if (w_beat) begin
               w_m_valid_nxt = 1'b1;
               w_m_data_nxt  = w_sel_data;
               w_m_last_nxt  = w_src_last || !channel_up || w_wd_hit;
            end else begin
               w_m_valid_nxt = 1'b0;
            end
            // A genuine last wins over a simultaneous link drop: no abort
            if (w_beat && w_src_last) begin
               w_state_nxt = IDLE;
               w_gnt_nxt   = '0;
               w_rr_nxt    = w_ptr_inc;
            end else if (!channel_up || w_wd_hit) begin
               w_state_nxt = IDLE;
               w_gnt_nxt   = '0;
               w_rr_nxt    = w_ptr_inc;
               w_abort_nxt = 1'b1;
            end else begin
               w_state_nxt = BUSY;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_gnt_nxt   = '0;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_gnt     <= '0;
         r_winner  <= '0;
         r_rr_ptr  <= '0;
         r_m_valid <= 1'b0;
         r_m_last  <= 1'b0;
         r_m_data  <= 64'd0;
         r_abort   <= 1'b0;
         r_stray   <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_gnt     <= w_gnt_nxt;
         r_winner  <= w_winner_nxt;
         r_rr_ptr  <= w_rr_nxt;
         r_m_valid <= w_m_valid_nxt;
         r_m_last  <= w_m_last_nxt;
         r_m_data  <= w_m_data_nxt;
         r_abort   <= w_abort_nxt;
         r_stray   <= w_stray_nxt;
      end
   end

   assign gnt          = r_gnt;
   assign m_axis.valid = r_m_valid;
   assign m_axis.last  = r_m_last;
   assign m_axis.data  = r_m_data;
   assign abort        = r_abort;
   assign stray        = r_stray;

endmodule

// File: tb/tb_axis_frame_arbiter.sv
// Self-checking bench for axis_frame_arbiter: directed table, corner sequences
// and randomized traffic checked against a behavioural frame-level model.
module tb_axis_frame_arbiter;

   localparam int N  = 2;
   localparam int MB = 4;
`ifdef AXIS_ARB_WATCHDOG_EN
   localparam bit WD = 1'b1;
`else
   localparam bit WD = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            rst;
   logic            channel_up;
   logic [N-1:0]    req;
   logic [N-1:0]    gnt;
   logic [N-1:0]    s_valid;
   logic [N-1:0]    s_last;
   logic [64*N-1:0] s_data;
   logic            abort;
   logic            stray;

   axi_stream_if m_if ();

   axis_frame_arbiter #(.N_SRC(N), .MAX_BEATS(MB)) dut (
      .clk        (clk),
      .rst        (rst),
      .channel_up (channel_up),
      .req        (req),
      .gnt        (gnt),
      .s_valid    (s_valid),
      .s_last     (s_last),
      .s_data     (s_data),
      .m_axis     (m_if),
      .abort      (abort),
      .stray      (stray)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;
   bit mchk  = 1'b0;

   // Behavioural model state
   bit          m_busy;
   int          m_owner;
   int          m_ptr;
   int          m_cnt;
   logic [1:0]  e_gnt;
   logic        e_v, e_l, e_a, e_s;
   logic [63:0] e_d;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_update();
      bit beat, fin, ab, found;
      int k;
      if (rst) begin
         m_busy = 0; m_owner = 0; m_ptr = 0; m_cnt = 0;
         e_v = 0; e_l = 0; e_a = 0; e_s = 0; e_d = 64'd0; e_gnt = 2'b00;
         return;
      end
      e_s = 1'b0;
      for (int j = 0; j < N; j++)
         if (s_valid[j] && !(m_busy && m_owner == j)) e_s = 1'b1;
      e_v = 1'b0; e_l = 1'b0; e_a = 1'b0;
      if (!m_busy) begin
         found = 0;
         if (channel_up && req != 0) begin
            for (int i = 0; i < N; i++) begin
               k = (m_ptr + i) % N;
               if (!found && req[k]) begin
                  found = 1; m_busy = 1; m_owner = k; m_cnt = 0;
               end
            end
         end
      end else begin
         beat = s_valid[m_owner];
         fin = 0; ab = 0;
         if (beat) begin
            e_v = 1'b1;
            e_d = s_data[m_owner*64 +: 64];
            m_cnt++;
         end
         if (beat && s_last[m_owner]) fin = 1;
         else if (!channel_up) begin fin = 1; ab = 1; end
         else if (WD && beat && m_cnt == MB) begin fin = 1; ab = 1; end
         e_l = beat && fin;
         e_a = ab;
         if (fin) begin
            m_busy = 0;
            m_ptr  = (m_owner + 1) % N;
         end
      end
      e_gnt = m_busy ? (2'b01 << m_owner) : 2'b00;
   endtask

   task automatic step();
      @(posedge clk);
      model_update();
      #1;
      if (mchk) begin
         chk("rnd_gnt",   64'(gnt),          64'(e_gnt));
         chk("rnd_valid", 64'(m_if.valid),   64'(e_v));
         chk("rnd_last",  64'(m_if.last),    64'(e_l));
         chk("rnd_data",  m_if.data,         e_d);
         chk("rnd_abort", 64'(abort),        64'(e_a));
         chk("rnd_stray", 64'(stray),        64'(e_s));
      end
   endtask

   task automatic drv(input logic r, input logic cu, input logic [1:0] rq,
                      input logic [1:0] sv, input logic [1:0] sl,
                      input logic [63:0] d0, input logic [63:0] d1);
      rst = r; channel_up = cu; req = rq; s_valid = sv; s_last = sl;
      s_data = {d1, d0};
   endtask

   typedef struct {
      logic        r;
      logic        cu;
      logic [1:0]  rq;
      logic [1:0]  sv;
      logic [1:0]  sl;
      logic [63:0] d0;
      logic [1:0]  x_gnt;
      logic        x_v;
      logic        x_l;
      logic [63:0] x_d;
      logic        x_a;
      logic        x_s;
   } vec_t;

   vec_t tbl [7];

   initial begin
      // Basic 3-beat frame on src0
      tbl[0] = '{1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 64'h00, 2'b00, 1'b0, 1'b0, 64'h00, 1'b0, 1'b0};
      tbl[1] = '{1'b0, 1'b1, 2'b01, 2'b00, 2'b00, 64'h00, 2'b01, 1'b0, 1'b0, 64'h00, 1'b0, 1'b0};
      tbl[2] = '{1'b0, 1'b1, 2'b00, 2'b01, 2'b00, 64'h11, 2'b01, 1'b1, 1'b0, 64'h11, 1'b0, 1'b0};
      tbl[3] = '{1'b0, 1'b1, 2'b00, 2'b01, 2'b00, 64'h22, 2'b01, 1'b1, 1'b0, 64'h22, 1'b0, 1'b0};
      tbl[4] = '{1'b0, 1'b1, 2'b00, 2'b01, 2'b01, 64'h33, 2'b00, 1'b1, 1'b1, 64'h33, 1'b0, 1'b0};
      tbl[5] = '{1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 64'h00, 2'b00, 1'b0, 1'b0, 64'h33, 1'b0, 1'b0};
      tbl[6] = '{1'b0, 1'b1, 2'b00, 2'b10, 2'b00, 64'h00, 2'b00, 1'b0, 1'b0, 64'h33, 1'b0, 1'b1};

      drv(1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 64'd0, 64'd0);
      step();
      for (int i = 0; i < 7; i++) begin
         drv(tbl[i].r, tbl[i].cu, tbl[i].rq, tbl[i].sv, tbl[i].sl, tbl[i].d0, 64'hdead);
         step();
         chk($sformatf("tbl%0d_gnt", i),   64'(gnt),        64'(tbl[i].x_gnt));
         chk($sformatf("tbl%0d_valid", i), 64'(m_if.valid), 64'(tbl[i].x_v));
         chk($sformatf("tbl%0d_last", i),  64'(m_if.last),  64'(tbl[i].x_l));
         chk($sformatf("tbl%0d_data", i),  m_if.data,       tbl[i].x_d);
         chk($sformatf("tbl%0d_abort", i), 64'(abort),      64'(tbl[i].x_a));
         chk($sformatf("tbl%0d_stray", i), 64'(stray),      64'(tbl[i].x_s));
      end

      // Link down blocks grants; raising it grants on the next edge
      for (int i = 0; i < 10; i++) begin
         drv(1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 64'd0, 64'd0);
         step();
         chk("linkdown_gnt", 64'(gnt), 64'd0);
      end
      drv(1'b0, 1'b1, 2'b01, 2'b00, 2'b00, 64'd0, 64'd0);
      step();
      chk("linkup_gnt", 64'(gnt), 64'h1);
      drv(1'b0, 1'b1, 2'b00, 2'b01, 2'b01, 64'h44, 64'd0);
      step();
      chk("linkup_end_gnt", 64'(gnt), 64'h0);

      // Alternating grants with both sources requesting
      drv(1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 64'd0, 64'd0);
      step();
      drv(1'b0, 1'b1, 2'b11, 2'b00, 2'b00, 64'd0, 64'd0);
      step();
      for (int g = 0; g < 4; g++) begin
         logic [1:0] cur;
         chk($sformatf("rr%0d_gnt", g), 64'(gnt), (g % 2 == 0) ? 64'h1 : 64'h2);
         cur = gnt;
         drv(1'b0, 1'b1, 2'b11, cur, cur, 64'(100 + g), 64'(200 + g));
         step();
         chk($sformatf("rr%0d_gap", g), 64'(gnt), 64'h0);
         chk($sformatf("rr%0d_data", g), m_if.data, (g % 2 == 0) ? 64'(100 + g) : 64'(200 + g));
         drv(1'b0, 1'b1, 2'b11, 2'b00, 2'b00, 64'd0, 64'd0);
         step();
      end

      // Link drop on beat 2 of a 5-beat frame
      drv(1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 64'd0, 64'd0);
      step();
      drv(1'b0, 1'b1, 2'b01, 2'b00, 2'b00, 64'd0, 64'd0);
      step();
      chk("drop_gnt0", 64'(gnt), 64'h1);
      drv(1'b0, 1'b1, 2'b00, 2'b01, 2'b00, 64'ha1, 64'd0);
      step();
      chk("drop_b1_last", 64'(m_if.last), 64'h0);
      drv(1'b0, 1'b0, 2'b00, 2'b01, 2'b00, 64'ha2, 64'd0);
      step();
      chk("drop_b2_valid", 64'(m_if.valid), 64'h1);
      chk("drop_b2_last",  64'(m_if.last),  64'h1);
      chk("drop_b2_data",  m_if.data,       64'ha2);
      chk("drop_abort",    64'(abort),      64'h1);
      chk("drop_gnt",      64'(gnt),        64'h0);
      drv(1'b0, 1'b1, 2'b00, 2'b01, 2'b00, 64'ha3, 64'd0);
      step();
      chk("drop_b3_stray", 64'(stray),      64'h1);
      chk("drop_b3_valid", 64'(m_if.valid), 64'h0);
      chk("drop_abort_1x", 64'(abort),      64'h0);

      // Reset on beat 3; pointer returns to src0 (it was at src1)
      drv(1'b0, 1'b1, 2'b01, 2'b00, 2'b00, 64'd0, 64'd0);
      step();
      chk("rst_gnt0", 64'(gnt), 64'h1);
      drv(1'b0, 1'b1, 2'b00, 2'b01, 2'b00, 64'hb1, 64'd0);
      step();
      drv(1'b0, 1'b1, 2'b00, 2'b01, 2'b00, 64'hb2, 64'd0);
      step();
      drv(1'b1, 1'b1, 2'b00, 2'b01, 2'b00, 64'hb3, 64'd0);
      step();
      chk("rst_gnt",   64'(gnt),        64'h0);
      chk("rst_valid", 64'(m_if.valid), 64'h0);
      chk("rst_last",  64'(m_if.last),  64'h0);
      chk("rst_data",  m_if.data,       64'h0);
      drv(1'b0, 1'b1, 2'b11, 2'b00, 2'b00, 64'd0, 64'd0);
      step();
      chk("rst_ptr_gnt", 64'(gnt), 64'h1);
      drv(1'b0, 1'b1, 2'b00, 2'b01, 2'b01, 64'hb4, 64'd0);
      step();

`ifdef AXIS_ARB_WATCHDOG_EN
      // 6-beat frame against a 4-beat limit
      drv(1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 64'd0, 64'd0);
      step();
      drv(1'b0, 1'b1, 2'b01, 2'b00, 2'b00, 64'd0, 64'd0);
      step();
      for (int b = 1; b <= 6; b++) begin
         drv(1'b0, 1'b1, 2'b00, 2'b01, (b == 6) ? 2'b01 : 2'b00, 64'(b), 64'd0);
         step();
         chk($sformatf("wd%0d_valid", b), 64'(m_if.valid), (b <= 4) ? 64'h1 : 64'h0);
         chk($sformatf("wd%0d_last", b),  64'(m_if.last),  (b == 4) ? 64'h1 : 64'h0);
         chk($sformatf("wd%0d_abort", b), 64'(abort),      (b == 4) ? 64'h1 : 64'h0);
         chk($sformatf("wd%0d_stray", b), 64'(stray),      (b > 4)  ? 64'h1 : 64'h0);
         chk($sformatf("wd%0d_gnt", b),   64'(gnt),        (b < 4)  ? 64'h1 : 64'h0);
      end
`endif

      // Randomized traffic against the model
      drv(1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 64'd0, 64'd0);
      step();
      mchk = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         rst        = ($urandom_range(0, 249) == 0);
         channel_up = ($urandom_range(0, 11) != 0);
         req        = 2'($urandom);
         s_valid    = 2'($urandom) & 2'($urandom | 32'h1);
         s_last     = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
         s_data     = {$urandom, $urandom, $urandom, $urandom};
         step();
      end
      mchk = 1'b0;

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
